// File: rtl/cfg_pkg.sv
// Shared constants and FSM encoding for the serial configuration loader.
// Frame length depends on CFG_PARITY_EN (adds one even-parity bit).
package cfg_pkg;

  localparam logic [7:0]  SYNC_WORD = 8'hA5;
  localparam int unsigned ROOF_W    = 25;
  localparam int unsigned ROUTE_W   = 10;
  localparam int unsigned PAYLOAD_W = ROOF_W + ROUTE_W;
  localparam int unsigned CNT_W     = 6;

`ifdef CFG_PARITY_EN
  localparam int unsigned FRAME_W = PAYLOAD_W + 1;
`else
  localparam int unsigned FRAME_W = PAYLOAD_W;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/cfg_shift_reg.sv
// Serial-in shadow register, MSB first, with synchronous clear taking
// priority over shift.
module cfg_shift_reg #(
  parameter int unsigned W = 35
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= {q[W-2:0], din};
  end

endmodule

// File: rtl/config_loader.sv
// Serial configuration loader: hunts for the sync word, shifts in one frame
// and commits roof/in1or2roof on a passing check. CFG_PARITY_EN adds parity.
import cfg_pkg::*;

module config_loader (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_start,
  input  logic               cfg_data,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  output logic [ROOF_W-1:0]  roof,
  output logic [ROUTE_W-1:0] in1or2roof,
  output logic               cfg_done,
  output logic               cfg_error
);

  state_t             state, state_nxt;
  logic [6:0]         window;
  logic [7:0]         window_nxt;
  logic [CNT_W-1:0]   count;
  logic [FRAME_W-1:0] shadow;
  logic               accept;
  logic               last_bit;
  logic               check_pass;

  // cfg_start outranks a coincident bit, so that bit is never accepted.
  assign accept     = cfg_valid & cfg_ready & ~cfg_start;
  // Only the previous 7 bits are stored; the live bit completes the 8-bit window.
  assign window_nxt = {window, cfg_data};
  assign last_bit   = (count == CNT_W'(FRAME_W - 1));

`ifdef CFG_PARITY_EN
  assign check_pass = ~(^shadow);
`else
  assign check_pass = 1'b1;
`endif

  cfg_shift_reg #(.W(FRAME_W)) u_shift (
    .clk   (clk),
    .reset (reset),
    .clr   (cfg_start),
    .en    ((state == LOAD) && accept),
    .din   (cfg_data),
    .q     (shadow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (cfg_start) state_nxt = SYNC;
      SYNC: begin
        if (cfg_start)                                 state_nxt = SYNC;
        else if (accept && (window_nxt == SYNC_WORD))  state_nxt = LOAD;
      end
      LOAD: begin
        if (cfg_start)             state_nxt = SYNC;
        else if (accept && last_bit) state_nxt = CHECK;
      end
      CHECK: begin
        if (cfg_start)       state_nxt = SYNC;
        else if (check_pass) state_nxt = DONE;
        else                 state_nxt = ERROR;
      end
      DONE, ERROR: if (cfg_start) state_nxt = SYNC;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state == SYNC) || (state == LOAD);
    cfg_done  = (state == DONE);
`ifdef CFG_PARITY_EN
    cfg_error = (state == ERROR);
`else
    cfg_error = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window     <= '0;
      count      <= '0;
      roof       <= '0;
      in1or2roof <= '0;
    end else if (cfg_start) begin
      window <= '0;
      count  <= '0;
    end else begin
      if ((state == SYNC) && accept)
        window <= window_nxt[6:0];
      if ((state == LOAD) && accept && !last_bit)
        count <= count + 1'b1;
      if ((state == CHECK) && check_pass) begin
        roof       <= shadow[FRAME_W-1 -: ROOF_W];
        in1or2roof <= shadow[FRAME_W-1-ROOF_W -: ROUTE_W];
      end
    end
  end

endmodule
